// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the memory-stage responder.
package mem_responder_pkg;

  localparam int unsigned WORD_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  // Word-index width for an array of 'depth' words (depth is a power of two).
  function automatic int unsigned idx_w(input int unsigned depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/mem_responder_array.sv
// Single-port word storage: synchronous write, registered read, shared enable.
module mem_responder_array
  import mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned AW          = 8
) (
  input  logic              clk,
  input  logic              i_en,
  input  logic              i_we,
  input  logic [AW-1:0]     i_addr,
  input  logic [WORD_W-1:0] i_wdata,
  output logic [WORD_W-1:0] o_rdata
);

  logic [WORD_W-1:0] r_mem [DEPTH_WORDS];
  logic [WORD_W-1:0] r_rdata;

  // One access per enabled edge: commit the write, or register the read word.
  always_ff @(posedge clk) begin
    if (i_en) begin
      if (i_we) begin
        r_mem[i_addr] <= i_wdata;
      end else begin
        r_rdata <= r_mem[i_addr];
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_responder.sv
// Multi-cycle data memory responder with a one-entry write-through read buffer.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] Addr,
  input  logic [WORD_W-1:0] DataIn,
  input  logic              Rd,
  input  logic              Wr,
  input  logic              createdump,
  output logic [WORD_W-1:0] DataOut,
  output logic              Done,
  output logic              Stall,
  output logic              CacheHit,
  output logic              err
);

  localparam int unsigned IW = idx_w(DEPTH_WORDS);
  localparam int unsigned CW = $clog2(LATENCY);

  state_t            r_state;
  logic [CW-1:0]     r_cnt;
  logic              r_op_wr;
  logic [IW-1:0]     r_idx;
  logic [WORD_W-1:0] r_wdata;
  logic              r_buf_valid;
  logic [IW-1:0]     r_buf_tag;
  logic [WORD_W-1:0] r_buf_data;
  logic              r_done;
  logic              r_stall;
  logic              r_hit;
  logic              r_err;

  logic [IW-1:0]     w_idx;
  logic              w_req;
  logic              w_bad;
  logic              w_hit;
  logic              w_arr_en;
  logic [WORD_W-1:0] w_arr_rdata;
  logic [WORD_W-1:0] w_dout;
  logic              w_unused;

  // Upper address bits wrap; createdump is accepted but has no effect.
  assign w_unused = ^{createdump, Addr};

  assign w_idx    = Addr[IW:1];
  assign w_req    = Rd | Wr;
  assign w_bad    = Addr[0] | (Rd & Wr);
  assign w_hit    = Rd & r_buf_valid & (r_buf_tag == w_idx);
  assign w_arr_en = (r_state == BUSY) && (r_cnt == '0);

  mem_responder_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (IW)
  ) u_array (
    .clk     (clk),
    .i_en    (w_arr_en),
    .i_we    (r_op_wr),
    .i_addr  (r_idx),
    .i_wdata (r_wdata),
    .o_rdata (w_arr_rdata)
  );

  // Read data is driven only in the Done cycle of a successful read.
  always_comb begin
    w_dout = '0;
    if (r_state == RESP && !r_err && !r_op_wr) begin
      w_dout = r_hit ? r_buf_data : w_arr_rdata;
    end
  end

  // Request FSM with latency counter, read buffer and registered handshake outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_op_wr     <= 1'b0;
      r_idx       <= '0;
      r_wdata     <= '0;
      r_buf_valid <= 1'b0;
      r_buf_tag   <= '0;
      r_buf_data  <= '0;
      r_done      <= 1'b0;
      r_stall     <= 1'b0;
      r_hit       <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_hit  <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_req) begin
            r_op_wr <= Wr;
            if (w_bad) begin
              r_err   <= 1'b1;
              r_done  <= 1'b1;
              r_state <= RESP;
            end else if (w_hit) begin
              r_hit   <= 1'b1;
              r_done  <= 1'b1;
              r_state <= RESP;
            end else begin
              r_idx   <= w_idx;
              r_wdata <= DataIn;
              r_cnt   <= CW'(LATENCY - 2);
              r_stall <= 1'b1;
              r_state <= BUSY;
            end
          end
        end
        BUSY: begin
          if (r_cnt == '0) begin
            // Array access happens on this edge; keep the buffer coherent with writes.
            r_stall <= 1'b0;
            r_done  <= 1'b1;
            r_state <= RESP;
            if (r_op_wr && r_buf_valid && (r_buf_tag == r_idx)) begin
              r_buf_data <= r_wdata;
            end
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        RESP: begin
          r_state <= IDLE;
          if (!r_op_wr && !r_err && !r_hit) begin
            r_buf_valid <= 1'b1;
            r_buf_tag   <= r_idx;
            r_buf_data  <= w_arr_rdata;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign DataOut  = w_dout;
  assign Done     = r_done;
  assign Stall    = r_stall;
  assign CacheHit = r_hit;
  assign err      = r_err;

endmodule

// File: doc/mem_responder.md
# mem_responder

Responder side of the memory-stage request interface: accepts single-word read/write requests from the memory stage (Addr, DataIn, Rd, Wr) and answers with Stall/Done/DataOut/CacheHit/err. It models a multi-cycle data memory with a configurable access latency and a one-entry read buffer. It sits behind the memory stage in place of the single-cycle aligned memory, so the pipeline stall path is exercised under realistic timing.

## Interface
- DEPTH_WORDS, 256: number of 16-bit words; power of two.
- LATENCY, 4: cycles from request acceptance to Done on a miss; at least 2.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- Addr  in  16  byte address; word index = Addr[log2(DEPTH_WORDS):1].
- DataIn  in  16  write data.
- Rd  in  1  read request.
- Wr  in  1  write request.
- createdump  in  1  accepted for interface compatibility; no effect.
- DataOut  out  16  read data; valid only while Done=1 on a read, otherwise 0.
- Done  out  1  one-cycle completion pulse.
- Stall  out  1  high while a request is in progress.
- CacheHit  out  1  high with Done when a read was served from the read buffer.
- err  out  1  high with Done when the request was rejected.

## Operation
- States: IDLE, BUSY, RESP.
- IDLE: a request is present when Rd|Wr=1, and it is sampled at the clock edge.
  - Rejected if Addr[0]=1 or Rd&Wr=1: go to RESP with err=1; no array access; buffer unchanged.
  - Read hit (buffer valid and tag == word index): go to RESP with CacheHit=1 and DataOut = buffer data.
  - Otherwise latch op, index, and DataIn; load the counter with LATENCY-2; go to BUSY.
- BUSY: Stall=1; the counter decrements each cycle.
  - At 0, the array is accessed at that edge (write commits, or read data registers).
  - Next state is RESP.
- RESP: Done=1, Stall=0 for exactly one cycle, then IDLE.
  - A completed miss read fills the buffer (tag, data, valid=1).
- Writes are write-through: a completed write whose index matches the buffer tag also updates the buffer data.
- Inputs are ignored outside IDLE. The requester holds the request until Done, then deasserts or issues the next request.
- Upper address bits above the index wrap: Addr 0x0000 and 0x0000+2*DEPTH_WORDS alias.

## Timing
- Reset values: DataOut=0, Done=0, Stall=0, CacheHit=0, err=0, state IDLE, buffer valid=0. Array contents are not reset.
- Miss (read or write) sampled at edge N: Stall high in cycles N+1..N+LATENCY-1; Done in cycle N+LATENCY.
- Read hit or rejected request sampled at edge N: Done in cycle N+1, Stall never asserted.
- Minimum request spacing is one IDLE cycle after Done. A request held through RESP is re-sampled in the following IDLE cycle, so the requester must drop Rd/Wr in the Done cycle.
- Reset asserted mid-request: the request is aborted, a pending write is not committed, and no Done is produced.
- Write followed by a read to the same address: the read returns the new data, via buffer or array.

## Structure
- Package mem_responder_pkg: state enum (IDLE, BUSY, RESP), WORD_W=16, and a function deriving index width from DEPTH_WORDS.
- Sub-module mem_responder_array: DEPTH_WORDS x 16 storage, synchronous write, registered read, single port with an enable. The FSM, counter, and read buffer live in the top module.

## Test plan
- After reset, Rd=1 Addr=0x0010: Stall in cycles 1-3, Done in cycle 4, DataOut=array[8], CacheHit=0.
- Wr Addr=0x0020 DataIn=0xBEEF, then Rd Addr=0x0020: the write gets Done after 4 cycles; the read misses and returns 0xBEEF. A repeat read hits with Done after 1 cycle, CacheHit=1, DataOut=0xBEEF.
- Buffer holds 0x0020, then Wr 0x0020=0x1234, then Rd 0x0020: CacheHit=1, DataOut=0x1234 (write-through).
- Rd Addr=0x0021, and separately Rd=Wr=1: err=1 and Done one cycle later, DataOut=0, no array change, Stall never high.
- Wr 0x0040=0xAAAA with reset pulsed in cycle 2, then Rd 0x0040: no Done for the aborted write; the read misses and returns the old array contents, not 0xAAAA.
- With DEPTH_WORDS=256: Wr 0x0202=0x5555, then Rd 0x0002 returns 0x5555 (index wrap).
